mul_share_ctrl: RTL and testbench
=================================

Name: mul_share_ctrl

Overview:
- Two-requester round-robin controller that time-shares one sequential 16x16 signed multiplier: the radix-4 Booth unit with a start/busy handshake.
- Accepts operand pairs on per-requester valid/ready ports and drives the multiplier's start strobe with stable operands.
- Tracks busy, captures the 32-bit product and returns it on a single tagged response channel.
- Sits between the execute-stage requesters and the shared multiplier instance.

Parameters:
DATA_W, 16, operand width; product width is 2*DATA_W
RISE_TIMEOUT, 4, max cycles from start pulse to mul_busy rising before the op is aborted with an error

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  per-requester request valid
req_ready  out  2  per-requester accept, one-cycle pulse
req_x0  in  DATA_W  requester 0 multiplicand, signed
req_y0  in  DATA_W  requester 0 multiplier, signed
req_x1  in  DATA_W  requester 1 multiplicand, signed
req_y1  in  DATA_W  requester 1 multiplier, signed
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  1  requester index of the response
rsp_z  out  2*DATA_W  signed product
rsp_err  out  1  multiplier failed to raise busy
mul_x  out  DATA_W  operand to multiplier
mul_y  out  DATA_W  operand to multiplier
mul_start  out  1  start strobe
mul_busy  in  1  multiplier busy
mul_z  in  2*DATA_W  multiplier product

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_z=0, rsp_err=0, mul_start=0, mul_x=0, mul_y=0, last_grant=1 (so requester 0 wins first), state=IDLE.
- Reset mid-operation: abandons the op without producing a response. Any in-flight multiplier result is ignored.
- FSM states: IDLE, ISSUE, WAIT_RISE, WAIT_DONE, RESP.
- IDLE:
  - If any req_valid bit is set, grant one requester. If both are set, grant the one != last_grant; otherwise grant the single requester.
  - Pulse req_ready[g] for exactly that cycle. Latch x/y into mul_x/mul_y; latch g into rsp_id and last_grant. Go to ISSUE.
  - Requests are never accepted outside IDLE.
- ISSUE:
  - mul_start=1 for exactly one cycle; mul_x/mul_y stay stable until the op completes.
  - Clear the rise counter. Go to WAIT_RISE.
- WAIT_RISE:
  - mul_busy=1 -> WAIT_DONE.
  - Otherwise increment the counter. When it reaches RISE_TIMEOUT: rsp_z=0, rsp_err=1, go to RESP.
- WAIT_DONE:
  - On the first cycle mul_busy=0, capture mul_z into rsp_z, rsp_err=0, go to RESP.
  - No timeout in this state.
- RESP:
  - rsp_valid=1; rsp_z, rsp_id and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On that handshake: rsp_valid=0, go to IDLE. The next grant can happen on the following cycle.
- Latency, from accept to rsp_valid: 1 (ISSUE) + rise cycles + busy duration + 1. This is 11 cycles with the 8-cycle Booth unit and rsp_ready held high.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- Simultaneous events:
  - A requester dropping valid while not granted is allowed.
  - rsp_ready asserted before rsp_valid has no effect.
- Arithmetic: the product is full 2*DATA_W two's complement. The controller performs no truncation or sign manipulation.

Optional Feature:
- Macro: MUL_ZERO_BYPASS_EN.
- Defined: in IDLE, if the granted x==0 or y==0, skip ISSUE/WAIT states and go straight to RESP with rsp_z=0, rsp_err=0. mul_start is not pulsed. Latency from accept to rsp_valid is 1 cycle.
- Undefined: zero operands go through the multiplier like any other pair.

Decomposition:
- Shared package (mul_pkg) holds:
  - the FSM state enum (3-bit encoding);
  - DATA_W and the default RISE_TIMEOUT constants;
  - a typedef for the response bundle (id, z, err).
- One natural sub-module, rr_arb2: the 2-way round-robin grant logic.
  - Inputs: req[1:0], last_grant, en.
  - Outputs: gnt[1:0] (one-hot), gnt_idx.
- Multiplier instance stays outside; the bench instantiates the Booth unit plus a stub multiplier.

Test Plan:
- Single op: req0 x=3, y=5 with Booth unit attached, rsp_ready=1 -> rsp_valid after 11 cycles; rsp_z=32'h0000000F, rsp_id=0, rsp_err=0.
- Negative operand: req1 x=-7 (16'hFFF9), y=6 -> rsp_z=32'hFFFFFFD6, rsp_id=1.
- Extremes: 16'h7FFF*16'h7FFF -> 32'h3FFF0001; 16'h8000*16'h8000 -> 32'h40000000.
- Contention: both valid for 4 ops -> grant order 0,1,0,1; each req_ready is a single-cycle pulse; mul_start is exactly one cycle per op.
- Backpressure and timeout:
  - rsp_ready=0 for 5 cycles -> rsp_* held stable and no new grant; accept resumes the cycle after the handshake.
  - Stub with busy tied 0 -> rsp_err=1, rsp_z=0 after RISE_TIMEOUT+1 cycles.
- Reset and bypass:
  - rst_n low during WAIT_DONE -> all outputs return to reset values asynchronously; no stale response after release.
  - With MUL_ZERO_BYPASS_EN: x=0, y=1234 -> rsp_z=0 one cycle after accept, mul_start never asserted.

Source files
------------

// File: rtl/mul_share_ctrl_pkg.sv
// mul_pkg: shared types and defaults for the multiplier-sharing controller.
//   state_t          - controller FSM state (3-bit encoding)
//   DEF_DATA_W       - default operand width (product is twice this)
//   DEF_RISE_TIMEOUT - default cycles allowed from start to mul_busy rising
//   rsp_t            - response bundle (id, product, error) at default width
package mul_pkg;

  localparam int DEF_DATA_W       = 16;
  localparam int DEF_RISE_TIMEOUT = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_RISE = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  typedef struct packed {
    logic                    id;
    logic [2*DEF_DATA_W-1:0] z;
    logic                    err;
  } rsp_t;

endpackage

// File: rtl/mul_share_ctrl_if.sv
// mul_share_ctrl_if: request, response and multiplier-side signals of the
// multiplier-sharing controller.
//   slave  - controller view: takes requests, issues to the multiplier,
//            returns responses.
//   master - environment view: requesters, response sink, multiplier.
interface mul_share_ctrl_if #(
  parameter int DATA_W = 16
);

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [DATA_W-1:0]   req_x0;
  logic [DATA_W-1:0]   req_y0;
  logic [DATA_W-1:0]   req_x1;
  logic [DATA_W-1:0]   req_y1;

  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [2*DATA_W-1:0] rsp_z;
  logic                rsp_err;

  logic [DATA_W-1:0]   mul_x;
  logic [DATA_W-1:0]   mul_y;
  logic                mul_start;
  logic                mul_busy;
  logic [2*DATA_W-1:0] mul_z;

  modport slave (
    input  req_valid, req_x0, req_y0, req_x1, req_y1,
    output req_ready,
    output rsp_valid, rsp_id, rsp_z, rsp_err,
    input  rsp_ready,
    output mul_x, mul_y, mul_start,
    input  mul_busy, mul_z
  );

  modport master (
    output req_valid, req_x0, req_y0, req_x1, req_y1,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_z, rsp_err,
    output rsp_ready,
    input  mul_x, mul_y, mul_start,
    output mul_busy, mul_z
  );

endinterface

// File: rtl/mul_share_ctrl_arb.sv
// rr_arb2: two-way round-robin grant.
//   req[1:0]   - request bits
//   last_grant - index granted most recently
//   en         - grant allowed this cycle
//   gnt[1:0]   - one-hot grant (zero when disabled or no request)
//   gnt_idx    - index of the winner (meaningful only when gnt != 0)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    gnt_idx = 1'b0;
    gnt     = 2'b00;
    unique case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant;   // contention: the other one wins
      default: gnt_idx = 1'b0;
    endcase
    if (en && (req != 2'b00))
      gnt = gnt_idx ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: time-shares one sequential signed multiplier (start/busy
// handshake) between two requesters with round-robin arbitration, and returns
// each product on a single tagged response channel.
//   clk, rst_n     - clock, asynchronous active-low reset
//   bus.req_*      - per-requester valid/ready and signed operand pairs
//   bus.rsp_*      - response valid/ready, requester id, product, error
//   bus.mul_*      - operands, start strobe, busy and product of the multiplier
// Optional build macro MUL_ZERO_BYPASS_EN: a granted pair with a zero operand
// skips the multiplier and responds with zero one cycle after accept.
module mul_share_ctrl
  import mul_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int RISE_TIMEOUT = DEF_RISE_TIMEOUT
) (
  input logic             clk,
  input logic             rst_n,
  mul_share_ctrl_if.slave bus
);

  localparam int CNT_W = (RISE_TIMEOUT < 2) ? 1 : $clog2(RISE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] RISE_LIMIT = CNT_W'(RISE_TIMEOUT);

  state_t              state_q, state_d;
  logic                last_grant_q;
  logic [DATA_W-1:0]   mul_x_q, mul_y_q;
  logic                rsp_id_q, rsp_err_q;
  logic [2*DATA_W-1:0] rsp_z_q;
  logic [CNT_W-1:0]    rise_cnt_q, rise_cnt_inc;
  logic                rise_hit;

  logic [1:0]          gnt;
  logic                gnt_idx;
  logic                accept;
  logic                zero_op;
  logic [DATA_W-1:0]   sel_x, sel_y;

  rr_arb2 u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .en         (state_q == IDLE),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  assign accept = |gnt;
  assign sel_x  = gnt_idx ? bus.req_x1 : bus.req_x0;
  assign sel_y  = gnt_idx ? bus.req_y1 : bus.req_y0;

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (sel_x == '0) || (sel_y == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Counter of WAIT_RISE cycles spent without busy; hitting the limit aborts.
  assign rise_cnt_inc = rise_cnt_q + 1'b1;
  assign rise_hit     = (rise_cnt_inc == RISE_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 2'b00;
    bus.mul_start = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = gnt;
        if (accept) state_d = zero_op ? RESP : ISSUE;
      end
      ISSUE: begin
        bus.mul_start = 1'b1;
        state_d       = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (bus.mul_busy)  state_d = WAIT_DONE;
        else if (rise_hit) state_d = RESP;
      end
      WAIT_DONE: begin
        if (!bus.mul_busy) state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands and response fields only move on the events that own them, so
  // they stay stable for the multiplier and for a stalled response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;   // requester 0 wins the first contention
      mul_x_q      <= '0;
      mul_y_q      <= '0;
      rsp_id_q     <= 1'b0;
      rsp_z_q      <= '0;
      rsp_err_q    <= 1'b0;
      rise_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            mul_x_q      <= sel_x;
            mul_y_q      <= sel_y;
            rsp_id_q     <= gnt_idx;
            last_grant_q <= gnt_idx;
            if (zero_op) begin
              rsp_z_q   <= '0;
              rsp_err_q <= 1'b0;
            end
          end
        end
        ISSUE: rise_cnt_q <= '0;
        WAIT_RISE: begin
          if (!bus.mul_busy) begin
            rise_cnt_q <= rise_cnt_inc;
            if (rise_hit) begin
              rsp_z_q   <= '0;
              rsp_err_q <= 1'b1;
            end
          end
        end
        WAIT_DONE: begin
          if (!bus.mul_busy) begin
            rsp_z_q   <= bus.mul_z;
            rsp_err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mul_x   = mul_x_q;
  assign bus.mul_y   = mul_y_q;
  assign bus.rsp_id  = rsp_id_q;
  assign bus.rsp_z   = rsp_z_q;
  assign bus.rsp_err = rsp_err_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl: drives mul_share_ctrl with directed and randomized
// operations. A behavioural 8-cycle multiplier (optionally delayed busy rise,
// or a dead stub that never raises busy) sits on the multiplier side.
// Expected grants, products and latencies come from a reference model.
module tb_mul_share_ctrl;
  import mul_pkg::*;

  localparam int DW       = 16;
  localparam int TO       = 4;
  localparam int BUSY_LEN = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mul_share_ctrl_if #(.DATA_W(DW)) bus();

  mul_share_ctrl #(.DATA_W(DW), .RISE_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit model_last = 1'b1;

  // ---------------- multiplier model ----------------
  bit          stub_dead  = 1'b0;
  int          rise_extra = 0;
  int          m_cnt;
  logic [31:0] m_prod, m_z;

  function automatic logic [31:0] smul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    return sa * sb;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_prod <= '0; m_z <= '0;
    end else if (bus.mul_start && !stub_dead) begin
      m_cnt  <= rise_extra + BUSY_LEN;
      m_prod <= smul(bus.mul_x, bus.mul_y);
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_z <= m_prod;
    end
  end
  assign bus.mul_busy = (m_cnt != 0) && (m_cnt <= BUSY_LEN);
  assign bus.mul_z    = m_z;

  // ---------------- monitor ----------------
  int start_cnt = 0;
  int pulse_err = 0;
  int rr_run[2];
  int st_run = 0;
  always @(negedge clk) begin
    #2;
    if (bus.mul_start === 1'b1) begin start_cnt++; st_run++; end
    else st_run = 0;
    if (st_run > 1) pulse_err++;
    for (int i = 0; i < 2; i++) begin
      if (bus.req_ready[i] === 1'b1) rr_run[i]++;
      else rr_run[i] = 0;
      if (rr_run[i] > 1) pulse_err++;
    end
  end

  // ---------------- reference model ----------------
  function automatic int exp_grant(input logic [1:0] v, input bit last);
    if (v == 2'b11) return last ? 0 : 1;
    return v[1] ? 1 : 0;
  endfunction

  function automatic bit bypassed(input logic [15:0] x, input logic [15:0] y);
`ifdef MUL_ZERO_BYPASS_EN
    return (x == 16'd0) || (y == 16'd0);
`else
    return 1'b0;
`endif
  endfunction

  // accept -> rsp_valid: ISSUE + rise cycles + busy cycles + capture
  function automatic int exp_lat(input logic [15:0] x, input logic [15:0] y, input int e);
    if (bypassed(x, y)) return 1;
    return 1 + (e + 1) + BUSY_LEN + 1;
  endfunction

  // One operation: apply valids, wait for the grant, wait for the response,
  // hold rsp_ready low for 'stall' cycles, then complete the handshake.
  task automatic run_op(input logic [1:0] v, input logic [15:0] x0, input logic [15:0] y0,
                        input logic [15:0] x1, input logic [15:0] y1, input int stall,
                        output int g, output int lat, output logic [31:0] z,
                        output logic id, output logic err, output int ns);
    int s0, cyc;
    g = -1; lat = -1; z = 'x; id = 1'bx; err = 1'bx;
    s0 = start_cnt;
    @(negedge clk);
    bus.req_x0 = x0; bus.req_y0 = y0; bus.req_x1 = x1; bus.req_y1 = y1;
    bus.req_valid = v;
    bus.rsp_ready = (stall == 0);
    #1;
    cyc = 0;
    while (bus.req_ready == 2'b00 && cyc < 40) begin @(negedge clk); #1; cyc++; end
    if (bus.req_ready != 2'b00) begin
      g = bus.req_ready[1] ? 1 : 0;
      @(negedge clk); bus.req_valid = 2'b00; #1;
      lat = 1;
      while (!bus.rsp_valid && lat < 60) begin @(negedge clk); #1; lat++; end
      if (bus.rsp_valid) begin
        z = bus.rsp_z; id = bus.rsp_id; err = bus.rsp_err;
        if (stall > 0) begin repeat (stall) @(negedge clk); bus.rsp_ready = 1'b1; end
        @(negedge clk);
      end else lat = -1;
    end
    bus.req_valid = 2'b00;
    ns = start_cnt - s0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 2'b00; bus.rsp_ready = 1'b0;
    bus.req_x0 = '0; bus.req_y0 = '0; bus.req_x1 = '0; bus.req_y1 = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL reset req_ready: got %b want 00", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.mul_start !== 1'b0) begin failures++; $display("FAIL reset mul_start: got %b want 0", bus.mul_start); end
    checks++; if ({bus.mul_x, bus.mul_y} !== 32'h0) begin failures++; $display("FAIL reset mul_xy: got %h want 0", {bus.mul_x, bus.mul_y}); end
    checks++; if ({bus.rsp_id, bus.rsp_z, bus.rsp_err} !== 34'h0) begin failures++; $display("FAIL reset rsp_fields: got %h want 0", {bus.rsp_id, bus.rsp_z, bus.rsp_err}); end
    @(negedge clk); rst_n = 1'b1;
    model_last = 1'b1;
  endtask

  task automatic test_single();
    int g, lat, ns; logic [31:0] z; logic id, err;
    run_op(2'b01, 16'd3, 16'd5, 16'd0, 16'd0, 0, g, lat, z, id, err, ns);
    checks++; if (g !== 0) begin failures++; $display("FAIL single grant: got %0d want 0", g); end
    checks++; if (lat !== 11) begin failures++; $display("FAIL single latency: got %0d want 11", lat); end
    checks++; if (z !== 32'h0000000F) begin failures++; $display("FAIL single z: got %h want 0000000f", z); end
    checks++; if ({id, err} !== 2'b00) begin failures++; $display("FAIL single id_err: got %b want 00", {id, err}); end
    checks++; if (ns !== 1) begin failures++; $display("FAIL single starts: got %0d want 1", ns); end
    model_last = 1'b0;
  endtask

  task automatic test_negative();
    int g, lat, ns; logic [31:0] z; logic id, err;
    run_op(2'b10, 16'd0, 16'd0, 16'hFFF9, 16'd6, 0, g, lat, z, id, err, ns);
    checks++; if (g !== 1) begin failures++; $display("FAIL negative grant: got %0d want 1", g); end
    checks++; if (z !== 32'hFFFFFFD6) begin failures++; $display("FAIL negative z: got %h want ffffffd6", z); end
    checks++; if ({id, err} !== 2'b10) begin failures++; $display("FAIL negative id_err: got %b want 10", {id, err}); end
    checks++; if (lat !== 11) begin failures++; $display("FAIL negative latency: got %0d want 11", lat); end
    model_last = 1'b1;
  endtask

  task automatic test_extremes();
    int g, lat, ns; logic [31:0] z; logic id, err;
    run_op(2'b01, 16'h7FFF, 16'h7FFF, 16'd0, 16'd0, 0, g, lat, z, id, err, ns);
    checks++; if (z !== 32'h3FFF0001) begin failures++; $display("FAIL extreme_max z: got %h want 3fff0001", z); end
    checks++; if ({id, err} !== 2'b00) begin failures++; $display("FAIL extreme_max id_err: got %b want 00", {id, err}); end
    run_op(2'b10, 16'd0, 16'd0, 16'h8000, 16'h8000, 0, g, lat, z, id, err, ns);
    checks++; if (z !== 32'h40000000) begin failures++; $display("FAIL extreme_min z: got %h want 40000000", z); end
    checks++; if ({id, err} !== 2'b10) begin failures++; $display("FAIL extreme_min id_err: got %b want 10", {id, err}); end
    model_last = 1'b1;
  endtask

  task automatic test_contention();
    logic [15:0] ox[2], oy[2];
    logic [31:0] expz[$];
    int          expid[$];
    int accepts, resps, cyc, s0, p0, chg;
    accepts = 0; resps = 0; cyc = 0; chg = -1;
    s0 = start_cnt; p0 = pulse_err;
    stub_dead = 1'b0; rise_extra = 0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin ox[i] = 16'($urandom) | 16'h1; oy[i] = 16'($urandom) | 16'h1; end
    bus.req_x0 = ox[0]; bus.req_y0 = oy[0]; bus.req_x1 = ox[1]; bus.req_y1 = oy[1];
    bus.req_valid = 2'b11; bus.rsp_ready = 1'b1;
    while ((accepts < 4 || resps < 4) && cyc < 400) begin
      #1;
      if (bus.req_ready != 2'b00) begin
        int g;
        g = bus.req_ready[1] ? 1 : 0;
        checks++; if (g != exp_grant(2'b11, model_last)) begin failures++; $display("FAIL contention grant%0d: got %0d want %0d", accepts, g, exp_grant(2'b11, model_last)); end
        model_last = g[0];
        expz.push_back(smul(ox[g], oy[g])); expid.push_back(g);
        accepts++; chg = g;
      end
      if (bus.rsp_valid) begin
        if (expz.size() == 0) begin
          checks++; failures++; $display("FAIL contention spurious_rsp: got rsp_valid want none");
        end else begin
          logic [31:0] ez; int ei;
          ez = expz.pop_front(); ei = expid.pop_front();
          checks++; if (bus.rsp_z !== ez) begin failures++; $display("FAIL contention z%0d: got %h want %h", resps, bus.rsp_z, ez); end
          checks++; if ({bus.rsp_id, bus.rsp_err} !== {ei[0], 1'b0}) begin failures++; $display("FAIL contention id_err%0d: got %b want %b0", resps, {bus.rsp_id, bus.rsp_err}, ei[0]); end
        end
        resps++;
      end
      @(negedge clk); cyc++;
      if (accepts >= 4) bus.req_valid = 2'b00;
      if (chg >= 0) begin
        ox[chg] = 16'($urandom) | 16'h1; oy[chg] = 16'($urandom) | 16'h1;
        bus.req_x0 = ox[0]; bus.req_y0 = oy[0]; bus.req_x1 = ox[1]; bus.req_y1 = oy[1];
        chg = -1;
      end
    end
    bus.req_valid = 2'b00;
    checks++; if (accepts !== 4 || resps !== 4) begin failures++; $display("FAIL contention count: got %0d/%0d want 4/4", accepts, resps); end
    checks++; if (start_cnt - s0 !== 4) begin failures++; $display("FAIL contention starts: got %0d want 4", start_cnt - s0); end
    checks++; if (pulse_err !== p0) begin failures++; $display("FAIL contention pulse_width: got %0d long pulses want 0", pulse_err - p0); end
  endtask

  task automatic test_backpressure();
    int cyc, g;
    logic [31:0] ez;
    stub_dead = 1'b0; rise_extra = 0;
    @(negedge clk);
    bus.req_x0 = 16'h0123; bus.req_y0 = 16'hFF00; bus.req_valid = 2'b01; bus.rsp_ready = 1'b0;
    ez = smul(16'h0123, 16'hFF00);
    #1; cyc = 0;
    while (bus.req_ready == 2'b00 && cyc < 40) begin @(negedge clk); #1; cyc++; end
    g = bus.req_ready[1] ? 1 : 0;
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL backpressure grant: got %b want 01", bus.req_ready); end
    model_last = 1'b0;
    @(negedge clk);
    bus.req_x1 = 16'd77; bus.req_y1 = 16'hFFFE; bus.req_valid = 2'b10; #1;
    cyc = 0;
    while (!bus.rsp_valid && cyc < 60) begin @(negedge clk); #1; cyc++; end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_z !== ez || bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0 || bus.req_ready !== 2'b00) begin
        failures++;
        $display("FAIL backpressure hold%0d: got v=%b z=%h id=%b err=%b rdy=%b want v=1 z=%h id=0 err=0 rdy=00",
                 k, bus.rsp_valid, bus.rsp_z, bus.rsp_id, bus.rsp_err, bus.req_ready, ez);
      end
      if (k < 4) begin @(negedge clk); #1; end
    end
    @(negedge clk); bus.rsp_ready = 1'b1; #1;
    checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL backpressure final_valid: got %b want 1", bus.rsp_valid); end
    @(negedge clk); #1;
    checks++; if ({bus.rsp_valid, bus.req_ready} !== 3'b010) begin failures++; $display("FAIL backpressure resume: got v=%b rdy=%b want v=0 rdy=10", bus.rsp_valid, bus.req_ready); end
    model_last = 1'b1;
    @(negedge clk); bus.req_valid = 2'b00; #1;
    cyc = 0;
    while (!bus.rsp_valid && cyc < 60) begin @(negedge clk); #1; cyc++; end
    checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_z} !== {2'b11, smul(16'd77, 16'hFFFE)}) begin
      failures++; $display("FAIL backpressure second: got v=%b id=%b z=%h want v=1 id=1 z=%h", bus.rsp_valid, bus.rsp_id, bus.rsp_z, smul(16'd77, 16'hFFFE));
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int g, lat, ns; logic [31:0] z; logic id, err;
    stub_dead = 1'b1;
    run_op(2'b01, 16'h1234, 16'h0042, 16'd0, 16'd0, 0, g, lat, z, id, err, ns);
    stub_dead = 1'b0;
    model_last = 1'b0;
    checks++; if (lat !== TO + 2) begin failures++; $display("FAIL timeout latency: got %0d want %0d", lat, TO + 2); end
    checks++; if (z !== 32'h0) begin failures++; $display("FAIL timeout z: got %h want 0", z); end
    checks++; if ({id, err} !== 2'b01) begin failures++; $display("FAIL timeout id_err: got %b want 01", {id, err}); end
    checks++; if (ns !== 1) begin failures++; $display("FAIL timeout starts: got %0d want 1", ns); end
  endtask

  task automatic test_bypass();
    int g, lat, ns; logic [31:0] z; logic id, err;
    run_op(2'b01, 16'd0, 16'd1234, 16'd0, 16'd0, 0, g, lat, z, id, err, ns);
    model_last = 1'b0;
    checks++; if ({z, id, err} !== 34'h0) begin failures++; $display("FAIL bypass rsp: got z=%h id=%b err=%b want all 0", z, id, err); end
`ifdef MUL_ZERO_BYPASS_EN
    checks++; if (lat !== 1) begin failures++; $display("FAIL bypass latency: got %0d want 1", lat); end
    checks++; if (ns !== 0) begin failures++; $display("FAIL bypass starts: got %0d want 0", ns); end
`else
    checks++; if (lat !== 11) begin failures++; $display("FAIL bypass latency: got %0d want 11", lat); end
    checks++; if (ns !== 1) begin failures++; $display("FAIL bypass starts: got %0d want 1", ns); end
`endif
  endtask

  task automatic test_reset_mid();
    int cyc, seen, g, lat, ns; logic [31:0] z; logic id, err;
    stub_dead = 1'b0; rise_extra = 0;
    @(negedge clk);
    bus.req_x0 = 16'd100; bus.req_y0 = 16'd200; bus.req_valid = 2'b01; bus.rsp_ready = 1'b1;
    #1; cyc = 0;
    while (bus.req_ready == 2'b00 && cyc < 40) begin @(negedge clk); #1; cyc++; end
    @(negedge clk); bus.req_valid = 2'b00; #1;
    cyc = 0;
    while (!bus.mul_busy && cyc < 40) begin @(negedge clk); #1; cyc++; end
    checks++; if ({bus.mul_busy, bus.mul_x} !== {1'b1, 16'd100}) begin failures++; $display("FAIL reset_mid pre: got busy=%b x=%0d want busy=1 x=100", bus.mul_busy, bus.mul_x); end
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({bus.rsp_valid, bus.req_ready, bus.mul_start} !== 4'b0) begin failures++; $display("FAIL reset_mid ctrl: got %b want 0000", {bus.rsp_valid, bus.req_ready, bus.mul_start}); end
    checks++; if ({bus.mul_x, bus.mul_y} !== 32'h0) begin failures++; $display("FAIL reset_mid mul_xy: got %h want 0", {bus.mul_x, bus.mul_y}); end
    checks++; if ({bus.rsp_id, bus.rsp_z, bus.rsp_err} !== 34'h0) begin failures++; $display("FAIL reset_mid rsp: got %h want 0", {bus.rsp_id, bus.rsp_z, bus.rsp_err}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    seen = 0;
    repeat (20) begin @(negedge clk); #1; if (bus.rsp_valid) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL reset_mid stale: got %0d rsp cycles want 0", seen); end
    run_op(2'b11, 16'd7, 16'd9, 16'd11, 16'd13, 0, g, lat, z, id, err, ns);
    checks++; if (g !== exp_grant(2'b11, model_last)) begin failures++; $display("FAIL reset_mid grant: got %0d want 0", g); end
    checks++; if (z !== 32'd63) begin failures++; $display("FAIL reset_mid z: got %h want 3f", z); end
    model_last = 1'b0;
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_random();
    int g, lat, ns, eg, stall; logic [31:0] z; logic id, err;
    logic [1:0] v; logic [15:0] x[2], y[2];
    rsp_t exp_r, got_r;
    for (int n = 0; n < 24; n++) begin
      v = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin x[i] = pick_operand(); y[i] = pick_operand(); end
      rise_extra = $urandom_range(0, 2);
      stall = $urandom_range(0, 3);
      eg = exp_grant(v, model_last);
      run_op(v, x[0], y[0], x[1], y[1], stall, g, lat, z, id, err, ns);
      model_last = eg[0];
      exp_r = '{id: eg[0], z: smul(x[eg], y[eg]), err: 1'b0};
      got_r = '{id: id, z: z, err: err};
      checks++; if (g !== eg) begin failures++; $display("FAIL random%0d grant: got %0d want %0d", n, g, eg); end
      checks++; if (got_r !== exp_r) begin failures++; $display("FAIL random%0d rsp: got id=%b z=%h err=%b want id=%b z=%h err=0", n, id, z, err, exp_r.id, exp_r.z); end
      checks++; if (lat !== exp_lat(x[eg], y[eg], rise_extra)) begin failures++; $display("FAIL random%0d latency: got %0d want %0d", n, lat, exp_lat(x[eg], y[eg], rise_extra)); end
      checks++; if (ns !== (bypassed(x[eg], y[eg]) ? 0 : 1)) begin failures++; $display("FAIL random%0d starts: got %0d want %0d", n, ns, bypassed(x[eg], y[eg]) ? 0 : 1); end
    end
    rise_extra = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion want finish before 400000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_negative();
    test_extremes();
    test_contention();
    test_backpressure();
    test_timeout();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
